// File: rtl/alu_pkg.sv
// Shared types for the alu and the round-robin request arbiter in front of it.
package alu_pkg;

  typedef enum logic [3:0] {
    ALU_ADD = 4'h0,
    ALU_SUB = 4'h1,
    ALU_MUL = 4'h2,
    ALU_AND = 4'h3,
    ALU_OR  = 4'h4,
    ALU_XOR = 4'h5
  } alu_op_e;

  typedef enum logic [1:0] {
    IDLE,
    EXEC,
    RESP
  } arb_state_e;

endpackage

// File: rtl/alu.sv
// Combinational N-bit alu; result is 2N+1 bits with the MSB as carry/borrow.
module alu
  import alu_pkg::*;
#(
  parameter int N = 4
) (
  input  logic [N-1:0] op1,
  input  logic [N-1:0] op2,
  input  logic [3:0]   sel,
  output logic [2*N:0] alu_out
);

  always_comb begin
    alu_out = '0;
    case (alu_op_e'(sel))
      ALU_ADD: alu_out = (2*N+1)'(op1) + (2*N+1)'(op2);
      // Borrow propagates into every upper bit, so the MSB flags op1 < op2.
      ALU_SUB: alu_out = (2*N+1)'(op1) - (2*N+1)'(op2);
      ALU_MUL: alu_out = (2*N+1)'(op1) * (2*N+1)'(op2);
      ALU_AND: alu_out = (2*N+1)'(op1 & op2);
      ALU_OR:  alu_out = (2*N+1)'(op1 | op2);
      ALU_XOR: alu_out = (2*N+1)'(op1 ^ op2);
      default: alu_out = '0;
    endcase
  end

endmodule

// File: rtl/alu_arbiter.sv
// Round-robin arbiter sharing one alu among M valid/ready requesters,
// returning a tagged result on a single valid/ready response channel.
module alu_arbiter
  import alu_pkg::*;
#(
  parameter  int N     = 4,
  parameter  int M     = 4,
  parameter  int CNT_W = 16,
  localparam int ID_W  = $clog2(M)
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic [M-1:0]          req_valid,
  output logic [M-1:0]          req_ready,
  input  logic [M-1:0][N-1:0]   req_op1,
  input  logic [M-1:0][N-1:0]   req_op2,
  input  logic [M-1:0][3:0]     req_sel,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [2*N-1:0]        rsp_result,
  output logic                  rsp_flag,
  output logic [ID_W-1:0]       rsp_id,
  output logic                  busy,
  output logic [CNT_W-1:0]      op_count
);

  function automatic logic [ID_W-1:0] next_idx(input logic [ID_W-1:0] i);
    return (i == ID_W'(M - 1)) ? '0 : i + 1'b1;
  endfunction

  // Returns {found, index}: first valid requester starting at ptr, wrapping mod M.
  function automatic logic [ID_W:0] rr_pick(input logic [M-1:0] valid,
                                            input logic [ID_W-1:0] ptr);
    logic [ID_W-1:0] idx;
    logic [ID_W-1:0] pick;
    logic            found;
    idx   = ptr;
    pick  = '0;
    found = 1'b0;
    for (int k = 0; k < M; k++) begin
      if (!found && valid[idx]) begin
        found = 1'b1;
        pick  = idx;
      end
      idx = next_idx(idx);
    end
    return {found, pick};
  endfunction

  arb_state_e       state_q, state_d;
  logic [ID_W-1:0]  rr_ptr_q, rr_ptr_d;
  logic [N-1:0]     op1_q, op1_d;
  logic [N-1:0]     op2_q, op2_d;
  logic [3:0]       sel_q, sel_d;
  logic [ID_W-1:0]  id_q, id_d;
  logic             rsp_valid_q, rsp_valid_d;
  logic [2*N-1:0]   rsp_result_q, rsp_result_d;
  logic             rsp_flag_q, rsp_flag_d;
  logic [ID_W-1:0]  rsp_id_q, rsp_id_d;
  logic [CNT_W-1:0] op_count_q, op_count_d;

  logic             grant_found;
  logic [ID_W-1:0]  grant_idx;
  logic [2*N:0]     alu_out;

  alu #(.N(N)) u_alu (
    .op1     (op1_q),
    .op2     (op2_q),
    .sel     (sel_q),
    .alu_out (alu_out)
  );

  always_comb begin
    state_d      = state_q;
    rr_ptr_d     = rr_ptr_q;
    op1_d        = op1_q;
    op2_d        = op2_q;
    sel_d        = sel_q;
    id_d         = id_q;
    rsp_valid_d  = rsp_valid_q;
    rsp_result_d = rsp_result_q;
    rsp_flag_d   = rsp_flag_q;
    rsp_id_d     = rsp_id_q;
    op_count_d   = op_count_q;

    {grant_found, grant_idx} = rr_pick(req_valid, rr_ptr_q);
    // Grant is withheld while reset is asserted so no handshake appears to complete.
    req_ready = (state_q == IDLE && grant_found && reset_n) ? (M'(1) << grant_idx) : '0;

    case (state_q)
      IDLE: begin
        if (grant_found) begin
          op1_d    = req_op1[grant_idx];
          op2_d    = req_op2[grant_idx];
          sel_d    = req_sel[grant_idx];
          id_d     = grant_idx;
          rr_ptr_d = next_idx(grant_idx);
          state_d  = EXEC;
        end
      end
      EXEC: begin
        rsp_result_d = alu_out[2*N-1:0];
        rsp_flag_d   = alu_out[2*N];
        rsp_id_d     = id_q;
        rsp_valid_d  = 1'b1;
        state_d      = RESP;
      end
      RESP: begin
        if (rsp_ready) begin
          rsp_valid_d = 1'b0;
          op_count_d  = op_count_q + 1'b1;
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= IDLE;
      rr_ptr_q     <= '0;
      op1_q        <= '0;
      op2_q        <= '0;
      sel_q        <= '0;
      id_q         <= '0;
      rsp_valid_q  <= 1'b0;
      rsp_result_q <= '0;
      rsp_flag_q   <= 1'b0;
      rsp_id_q     <= '0;
      op_count_q   <= '0;
    end else begin
      state_q      <= state_d;
      rr_ptr_q     <= rr_ptr_d;
      op1_q        <= op1_d;
      op2_q        <= op2_d;
      sel_q        <= sel_d;
      id_q         <= id_d;
      rsp_valid_q  <= rsp_valid_d;
      rsp_result_q <= rsp_result_d;
      rsp_flag_q   <= rsp_flag_d;
      rsp_id_q     <= rsp_id_d;
      op_count_q   <= op_count_d;
    end
  end

  assign rsp_valid  = rsp_valid_q;
  assign rsp_result = rsp_result_q;
  assign rsp_flag   = rsp_flag_q;
  assign rsp_id     = rsp_id_q;
  assign busy       = (state_q != IDLE);
  assign op_count   = op_count_q;

endmodule

// File: tb/tb_alu_arbiter.sv
// Directed bench for alu_arbiter (N=4, M=4, CNT_W=4) with hand-computed results.
module tb_alu_arbiter;

  logic            clk = 1'b0;
  logic            reset_n = 1'b1;
  logic [3:0]      req_valid = '0;
  logic [3:0]      req_ready;
  logic [3:0][3:0] req_op1 = '0;
  logic [3:0][3:0] req_op2 = '0;
  logic [3:0][3:0] req_sel = '0;
  logic            rsp_valid;
  logic            rsp_ready = 1'b0;
  logic [7:0]      rsp_result;
  logic            rsp_flag;
  logic [1:0]      rsp_id;
  logic            busy;
  logic [3:0]      op_count;

  int tests = 0;
  int fails = 0;

  alu_arbiter #(.N(4), .M(4), .CNT_W(4)) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_op1    (req_op1),
    .req_op2    (req_op2),
    .req_sel    (req_sel),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_result (rsp_result),
    .rsp_flag   (rsp_flag),
    .rsp_id     (rsp_id),
    .busy       (busy),
    .op_count   (op_count)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    reset_n = 1'b1;
  endtask

  // Presents one op on requester id from IDLE; returns just after the accept edge.
  task automatic send_op(input int id, input logic [3:0] a, input logic [3:0] b,
                         input logic [3:0] s);
    req_op1[id] = a;
    req_op2[id] = b;
    req_sel[id] = s;
    req_valid = '0;
    req_valid[id] = 1'b1;
    tick();
    req_valid = '0;
  endtask

  task automatic test_reset();
    #2 reset_n = 1'b0;
    #1;
    tests++; if (rsp_valid !== 1'b0) begin fails++; $display("FAIL reset_rsp_valid: got %b want 0", rsp_valid); end
    tests++; if (rsp_result !== 8'h00) begin fails++; $display("FAIL reset_rsp_result: got %h want 00", rsp_result); end
    tests++; if (rsp_flag !== 1'b0) begin fails++; $display("FAIL reset_rsp_flag: got %b want 0", rsp_flag); end
    tests++; if (rsp_id !== 2'd0) begin fails++; $display("FAIL reset_rsp_id: got %0d want 0", rsp_id); end
    tests++; if (busy !== 1'b0) begin fails++; $display("FAIL reset_busy: got %b want 0", busy); end
    tests++; if (op_count !== 4'h0) begin fails++; $display("FAIL reset_op_count: got %h want 0", op_count); end
    tests++; if (req_ready !== 4'b0000) begin fails++; $display("FAIL reset_req_ready: got %b want 0000", req_ready); end
    @(posedge clk);
    #1 reset_n = 1'b1;
  endtask

  task automatic test_single_add();
    do_reset();
    rsp_ready = 1'b1;
    req_op1[2] = 4'h7; req_op2[2] = 4'h9; req_sel[2] = 4'h0;
    req_valid = 4'b0100;
    #1;
    tests++; if (req_ready !== 4'b0100) begin fails++; $display("FAIL add_grant: got %b want 0100", req_ready); end
    tick();
    req_valid = '0;
    tests++; if (busy !== 1'b1) begin fails++; $display("FAIL add_busy_exec: got %b want 1", busy); end
    tests++; if (rsp_valid !== 1'b0) begin fails++; $display("FAIL add_early_valid: got %b want 0", rsp_valid); end
    tick();
    tests++; if (rsp_valid !== 1'b1) begin fails++; $display("FAIL add_valid: got %b want 1", rsp_valid); end
    tests++; if (rsp_result !== 8'h10) begin fails++; $display("FAIL add_result: got %h want 10", rsp_result); end
    tests++; if (rsp_flag !== 1'b0) begin fails++; $display("FAIL add_flag: got %b want 0", rsp_flag); end
    tests++; if (rsp_id !== 2'd2) begin fails++; $display("FAIL add_id: got %0d want 2", rsp_id); end
    $display("[TB] add id=%0d result=%h flag=%b", rsp_id, rsp_result, rsp_flag);
    tick();
    tests++; if (rsp_valid !== 1'b0) begin fails++; $display("FAIL add_drop: got %b want 0", rsp_valid); end
    tests++; if (op_count !== 4'h1) begin fails++; $display("FAIL add_count: got %h want 1", op_count); end
  endtask

  task automatic test_round_robin();
    int         order [5] = '{0, 1, 2, 3, 0};
    logic [7:0] exp_res [4] = '{8'h03, 8'hE1, 8'h0F, 8'h02};
    logic [3:0] exp_rdy;
    do_reset();
    rsp_ready = 1'b1;
    req_op1[0] = 4'h1; req_op2[0] = 4'h2; req_sel[0] = 4'h0;
    req_op1[1] = 4'hF; req_op2[1] = 4'hF; req_sel[1] = 4'h2;
    req_op1[2] = 4'hA; req_op2[2] = 4'h5; req_sel[2] = 4'h5;
    req_op1[3] = 4'h5; req_op2[3] = 4'h3; req_sel[3] = 4'h1;
    req_valid = 4'hF;
    #1;
    for (int i = 0; i < 5; i++) begin
      exp_rdy = 4'b0001 << order[i];
      tests++; if (req_ready !== exp_rdy) begin fails++; $display("FAIL rr_grant%0d: got %b want %b", i, req_ready, exp_rdy); end
      tick();
      tick();
      tests++; if (rsp_id !== 2'(order[i])) begin fails++; $display("FAIL rr_id%0d: got %0d want %0d", i, rsp_id, order[i]); end
      tests++; if (rsp_result !== exp_res[order[i]]) begin fails++; $display("FAIL rr_result%0d: got %h want %h", i, rsp_result, exp_res[order[i]]); end
      $display("[TB] rr grant %0d id=%0d result=%h", i, rsp_id, rsp_result);
      tick();
    end
    req_valid = '0;
    tests++; if (op_count !== 4'h5) begin fails++; $display("FAIL rr_count: got %h want 5", op_count); end
  endtask

  task automatic test_backpressure();
    rsp_ready = 1'b0;
    send_op(3, 4'hC, 4'hA, 4'h3);
    req_op1[3] = 4'h0;
    req_valid = 4'hF;
    tick();
    for (int i = 0; i < 5; i++) begin
      tests++; if (rsp_valid !== 1'b1) begin fails++; $display("FAIL bp_valid%0d: got %b want 1", i, rsp_valid); end
      tests++; if (rsp_result !== 8'h08) begin fails++; $display("FAIL bp_result%0d: got %h want 08", i, rsp_result); end
      tests++; if (rsp_id !== 2'd3) begin fails++; $display("FAIL bp_id%0d: got %0d want 3", i, rsp_id); end
      tests++; if (req_ready !== 4'b0000) begin fails++; $display("FAIL bp_ready%0d: got %b want 0000", i, req_ready); end
      tests++; if (busy !== 1'b1) begin fails++; $display("FAIL bp_busy%0d: got %b want 1", i, busy); end
      tick();
    end
    $display("[TB] backpressure id=%0d result=%h", rsp_id, rsp_result);
    rsp_ready = 1'b1;
    tick();
    tests++; if (rsp_valid !== 1'b0) begin fails++; $display("FAIL bp_release: got %b want 0", rsp_valid); end
    tests++; if (op_count !== 4'h6) begin fails++; $display("FAIL bp_count: got %h want 6", op_count); end
    tests++; if (req_ready !== 4'b0001) begin fails++; $display("FAIL bp_next_grant: got %b want 0001", req_ready); end
    req_valid = '0;
  endtask

  task automatic test_sub_borrow();
    rsp_ready = 1'b1;
    send_op(0, 4'h3, 4'h5, 4'h1);
    tick();
    tests++; if (rsp_result !== 8'hFE) begin fails++; $display("FAIL sub_result: got %h want FE", rsp_result); end
    tests++; if (rsp_flag !== 1'b1) begin fails++; $display("FAIL sub_flag: got %b want 1", rsp_flag); end
    $display("[TB] sub id=%0d result=%h flag=%b", rsp_id, rsp_result, rsp_flag);
    tick();
  endtask

  task automatic test_reset_in_exec();
    do_reset();
    rsp_ready = 1'b1;
    send_op(1, 4'h1, 4'h1, 4'h0);
    tick();
    tick();
    send_op(2, 4'h4, 4'h4, 4'h0);
    #2 reset_n = 1'b0;
    #1;
    tests++; if (busy !== 1'b0) begin fails++; $display("FAIL exec_rst_busy: got %b want 0", busy); end
    tests++; if (op_count !== 4'h0) begin fails++; $display("FAIL exec_rst_count: got %h want 0", op_count); end
    @(posedge clk);
    #1 reset_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      tests++; if (rsp_valid !== 1'b0) begin fails++; $display("FAIL exec_rst_no_rsp%0d: got %b want 0", i, rsp_valid); end
    end
    req_valid = 4'b1010;
    #1;
    tests++; if (req_ready !== 4'b0010) begin fails++; $display("FAIL exec_rst_grant: got %b want 0010", req_ready); end
    tick();
    req_valid = '0;
    tick();
    tick();
    $display("[TB] post-reset id=%0d result=%h", rsp_id, rsp_result);
  endtask

  task automatic test_midstream_reset();
    rsp_ready = 1'b0;
    send_op(0, 4'h2, 4'h3, 4'h2);
    tick();
    req_valid = 4'hF;
    #3 reset_n = 1'b0;
    #1;
    tests++; if (rsp_valid !== 1'b0) begin fails++; $display("FAIL mid_rst_valid: got %b want 0", rsp_valid); end
    tests++; if (busy !== 1'b0) begin fails++; $display("FAIL mid_rst_busy: got %b want 0", busy); end
    tests++; if (req_ready !== 4'b0000) begin fails++; $display("FAIL mid_rst_ready: got %b want 0000", req_ready); end
    tests++; if (op_count !== 4'h0) begin fails++; $display("FAIL mid_rst_count: got %h want 0", op_count); end
    req_valid = '0;
    do_reset();
  endtask

  task automatic test_count_wrap();
    do_reset();
    rsp_ready = 1'b1;
    for (int i = 0; i < 15; i++) begin
      send_op(i % 4, 4'(i), 4'h1, 4'h0);
      tick();
      tick();
    end
    tests++; if (op_count !== 4'hF) begin fails++; $display("FAIL wrap_pre: got %h want F", op_count); end
    send_op(3, 4'h6, 4'h6, 4'h4);
    tick();
    tests++; if (rsp_result !== 8'h06) begin fails++; $display("FAIL wrap_or_result: got %h want 06", rsp_result); end
    tick();
    tests++; if (op_count !== 4'h0) begin fails++; $display("FAIL wrap_post: got %h want 0", op_count); end
    $display("[TB] wrap op_count=%h", op_count);
  endtask

  initial begin
    test_reset();
    test_single_add();
    test_round_robin();
    test_backpressure();
    test_sub_borrow();
    test_reset_in_exec();
    test_midstream_reset();
    test_count_wrap();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
